// File: rtl/debug_response_tx.sv
// Debug link response serializer: sends 1-4 bytes of a result LSB-first.
// Ports: clk, reset (async, active-high); cmd_valid/result/size from decoder;
//        tx_data/tx_start/tx_done to UART TX; busy, resp_done, overrun,
//        timeout_err status.
module debug_response_tx #(
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TMR_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [31:0] result,
    input  logic [1:0]  size,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        busy,
    output logic        resp_done,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam bit GAP_EN = (GAP_CYCLES != 0);
    localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);

    localparam logic [TMR_W:0] TO_LIM =
        (TMR_W+1)'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] GAP_LAST =
        TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [31:0]      shreg;
    logic [1:0]       rem;
    logic [TMR_W-1:0] timer;
    logic [TMR_W:0]   timer_inc;
    logic [31:0]      shreg_nxt;

    // One extra bit so the threshold compare cannot wrap.
    assign timer_inc = {1'b0, timer} + (TMR_W+1)'(1);
    assign shreg_nxt = {8'h00, shreg[31:8]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            shreg       <= '0;
            rem         <= '0;
            timer       <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            resp_done   <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start  <= 1'b0;
            resp_done <= 1'b0;

            if (cmd_valid && state != S_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        shreg    <= result;
                        rem      <= size;
                        tx_data  <= result[7:0];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        timer    <= '0;
                        state    <= S_SEND;
                    end
                end

                // Timer counts cycles since tx_start;
                // the SEND cycle itself is cycle 0.
                S_SEND: begin
                    timer <= TMR_W'(1);
                    state <= S_WAIT;
                end

                // tx_done has priority over the timeout
                // on the threshold cycle.
                S_WAIT: begin
                    if (tx_done) begin
                        if (rem == 2'd0) begin
                            resp_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            shreg <= shreg_nxt;
                            rem   <= rem - 2'd1;
                            timer <= '0;
                            if (GAP_EN) begin
                                state <= S_GAP;
                            end else begin
                                tx_data  <= shreg_nxt[7:0];
                                tx_start <= 1'b1;
                                state    <= S_SEND;
                            end
                        end
                    end else if (TO_EN && timer_inc >= TO_LIM) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer_inc[TMR_W-1:0];
                    end
                end

                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        tx_data  <= shreg[7:0];
                        tx_start <= 1'b1;
                        timer    <= '0;
                        state    <= S_SEND;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/debug_response_tx.md
Name: debug_response_tx

Overview:
- Response side of the debug link: takes the 32-bit `result` and 2-bit `size` produced when a debug command code is decoded, and serializes that value into 1–4 bytes.
- Bytes go out LSB-first through a byte-wide start/done handshake to the UART transmitter.
- Sits between the debug decoder outputs and the UART TX; one response per accepted command.

Parameters:
- GAP_CYCLES, 0: idle cycles inserted between consecutive bytes of one response (0 = back-to-back).
- TIMEOUT_CYCLES, 65535: maximum cycles to wait for `tx_done` after `tx_start`; 0 disables the timeout.
- TMR_W, 16: width of the gap/timeout counter; must hold max(GAP_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  one-cycle strobe: `result`/`size` valid for a newly decoded command.
- result  in  32  value to return.
- size  in  2  byte count minus one (00 = 1 byte, 01 = 2, 10 = 3, 11 = 4).
- tx_done  in  1  one-cycle pulse from UART TX: current byte fully sent.
- tx_data  out  8  byte presented to UART TX.
- tx_start  out  1  one-cycle pulse requesting transmission of `tx_data`.
- busy  out  1  high while a response is in progress (not IDLE).
- resp_done  out  1  one-cycle pulse: full response sent.
- overrun  out  1  sticky: `cmd_valid` arrived while busy.
- timeout_err  out  1  sticky: `tx_done` not received within TIMEOUT_CYCLES.

Behaviour:
- Reset (async, immediate, also mid-response):
  - state = IDLE.
  - `tx_data`=0, `tx_start`=0, `busy`=0, `resp_done`=0, `overrun`=0, `timeout_err`=0.
  - Shift register, byte counter and timer all cleared.
- States: IDLE, SEND, WAIT, GAP, DONE.
- IDLE:
  - On `cmd_valid`=1: latch `result` into a 32-bit shift register and `size` into a 2-bit remaining counter (rem).
  - Next state is SEND; `busy`=1 from the next cycle.
  - `tx_done` is ignored in IDLE.
- SEND (exactly one cycle):
  - `tx_start`=1, `tx_data`=shreg[7:0]; timer cleared.
  - Next state is WAIT.
  - Latency: `cmd_valid` at cycle N gives `tx_start` at cycle N+1.
- WAIT:
  - `tx_data` is held stable and the timer increments every cycle.
  - On `tx_done`: if rem==0, go to DONE. Otherwise shift shreg right by 8, decrement rem, and go to GAP (GAP_CYCLES>0) or SEND (GAP_CYCLES==0).
  - Timeout: if TIMEOUT_CYCLES≠0 and the timer reaches TIMEOUT_CYCLES with no `tx_done`, set `timeout_err`=1 and return to IDLE. No `resp_done` is issued and the rest of the response is discarded.
  - `tx_done` in the same cycle as the timeout threshold counts as success; the timeout does not fire.
- GAP:
  - Count GAP_CYCLES cycles, then go to SEND.
  - `tx_start`=0 throughout; `tx_done` is ignored.
- DONE (one cycle):
  - `resp_done`=1, `busy` still 1.
  - Next state is IDLE; `busy`=0 the following cycle.
- Byte order: byte k carries result[8k+7:8k], k = 0..size.
- Total `tx_start` pulses per response = size+1.
- `cmd_valid` in any state other than IDLE:
  - The command is dropped and `overrun`=1.
  - The in-flight response is unaffected, including `cmd_valid` in the DONE cycle.
- Sticky flags:
  - `overrun` and `timeout_err` clear only on reset.
  - Both are independent of normal operation; the block keeps accepting commands after either flag is set.
- Back-to-back commands:
  - `cmd_valid` on the cycle after DONE (state IDLE) is accepted normally.
  - Minimum spacing between accepted commands is therefore (size+1)·(2 + tx latency) + GAP overhead + 1 cycle.
- `tx_start` is never asserted while a previous byte is unacknowledged; at most one byte is outstanding.

Test Plan:
- Reset, then `cmd_valid` with `result`=0x000000A5, `size`=00, and `tx_done` 10 cycles after `tx_start` -> exactly one `tx_start` with `tx_data`=0xA5 at N+1; `resp_done` one cycle after `tx_done`; `busy` low afterwards.
- `result`=0x12345678, `size`=11, GAP_CYCLES=0 -> four `tx_start` pulses carrying 0x78, 0x56, 0x34, 0x12 in order; each `tx_start` is the cycle after the previous `tx_done`; one `resp_done`.
- GAP_CYCLES=3, `size`=01, `result`=0xBEEF -> bytes 0xEF then 0xBE, separated by 3 idle cycles after `tx_done` before the second `tx_start`.
- Second `cmd_valid` during WAIT of a 4-byte response -> original 4 bytes complete unchanged; `overrun`=1 and stays 1; no extra bytes sent.
- TIMEOUT_CYCLES=20, `tx_done` never returned -> `timeout_err`=1 exactly 20 cycles after `tx_start`; `busy`=0; no `resp_done`. A subsequent `cmd_valid` (`size`=00, 0x3C) is served normally.
- Assert `reset` during byte 2 of a 4-byte response -> all outputs 0 immediately (asynchronously); after release, a new command transmits from byte 0.
